// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM encoding and PC step.
package fetch_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC sequencer: issues word fetches, buffers one instruction for decode,
// and discards stale imem responses after a redirect.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic [31:0] pc_plus4,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        id_ready,
  output logic [31:0] fetch_count,
  output logic [2:0]  dbg_state
);

  // Handshakes: a request transfers on an edge where req_valid && req_ready; the
  // instruction transfers to decode on an edge where instr_valid && id_ready.
  // resp_valid is a one-cycle strobe, never in the cycle its request is accepted.

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    state_d       = state_q;
    // A redirect always retargets the PC, whatever the state.
    pc_d          = redirect ? next_pc : pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (req_ready) state_d = redirect ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_valid) begin
          if (redirect) begin
            state_d = ST_FETCH;
          end else begin
            state_d    = ST_HOLD;
            instr_d    = resp_data;
            instr_pc_d = pc_q;
            pc_d       = next_pc;
          end
        end else if (redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_FETCH;
        end else if (id_ready) begin
          state_d       = ST_FETCH;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      ST_DROP: begin
        // The in-flight response belongs to a stale address; swallow it.
        if (resp_valid) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_plus4    = pc_q + PC_STEP;
  assign req_valid   = (state_q == ST_FETCH);
  assign req_addr    = pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = fetch_count_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-stage program-counter sequencer for the 32-bit datapath. It holds the PC, exports PC+4 to the next-PC `Mux2_32b`, and takes the mux result back as `next_pc`. It issues word fetches to instruction memory over a valid/ready request with a separate response strobe. It buffers one fetched instruction for decode and discards stale responses after a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `next_pc`, input, 32: output of the next-PC `Mux2_32b`.
  - The mux is wired with in1 = `pc_plus4`, in2 = branch target, sel = `redirect`.
- `redirect`, input, 1: taken branch/jump from downstream; `next_pc` holds the target this cycle.
- `pc_plus4`, output, 32: combinational `pc + 4`, wraps modulo 2^32.
- `req_valid`, output, 1: fetch request valid.
- `req_ready`, input, 1: imem accepts the request this cycle.
- `req_addr`, output, 32: fetch address, always equals `pc`.
- `resp_valid`, input, 1: imem returns data.
  - Never asserted in the same cycle its request is accepted.
  - At most one response is outstanding.
- `resp_data`, input, 32: fetched instruction word.
- `instr_valid`, output, 1: buffered instruction is valid for decode.
- `instr`, output, 32: buffered instruction.
- `instr_pc`, output, 32: address `instr` was fetched from.
- `id_ready`, input, 1: decode consumes `instr` this cycle.
- `fetch_count`, output, 32: number of instructions delivered, wraps modulo 2^32.

## Operation
- States are IDLE, FETCH, WAIT, HOLD and DROP.
- Reset values:
  - state IDLE, `pc` = `RESET_PC`.
  - `instr_valid` = 0, `instr` = 0, `instr_pc` = 0, `fetch_count` = 0.
  - `req_valid` = 0.
- `req_valid` = 1 only in FETCH.
- `instr_valid` = 1 only in HOLD. `instr` and `instr_pc` are registered.
- IDLE: go to FETCH unconditionally.
- FETCH:
  - `req_ready` with no redirect → WAIT.
  - `req_ready` with redirect → DROP, and `pc` ← `next_pc` (the accepted request is now stale).
  - Redirect without `req_ready` → stay in FETCH, `pc` ← `next_pc`. `req_addr` changes while `req_valid` is held; this is permitted on redirect only.
- WAIT:
  - `resp_valid` with no redirect → HOLD. Capture `instr` ← `resp_data` and `instr_pc` ← `pc`, then `pc` ← `next_pc` (equal to `pc_plus4`).
  - `resp_valid` with redirect → FETCH. Discard the response and set `pc` ← `next_pc`.
  - Redirect without `resp_valid` → DROP, `pc` ← `next_pc`.
- DROP: on `resp_valid`, discard the response and go to FETCH. A redirect in DROP updates `pc` and stays in DROP.
- HOLD:
  - Redirect has priority: go to FETCH, `pc` ← `next_pc`, and the instruction is flushed (not counted).
  - Otherwise `id_ready` → FETCH and `fetch_count` increments.
  - Otherwise hold, with `instr` and `instr_pc` stable.
- IDLE redirect: `pc` ← `next_pc`, still go to FETCH.
- Asserting reset mid-operation discards any outstanding request or response. An imem response that arrives after reset is released is ignored, because the FSM leaves IDLE in FETCH without an outstanding request.

## Timing
- Reset release to first `req_valid`: 1 cycle.
- `resp_valid` to `instr_valid`: 1 cycle (registered).
- Back-to-back throughput is 1 instruction per 3 cycles: FETCH, WAIT, HOLD with zero-latency memory and `id_ready` held high.
- A redirect takes effect on the edge where it is sampled; the next `req_addr` is the target.
- `pc_plus4` updates in the same cycle as `pc` (combinational from the register).

## Structure
- Shared package `fetch_pkg`:
  - state encoding (IDLE=0, FETCH=1, WAIT=2, HOLD=3, DROP=4, 3 bits).
  - constant `PC_STEP = 32'd4`.
- No sub-module.
- The next-PC `Mux2_32b` stays external. It is instantiated beside this block in the fetch stage so that the mux bench remains reusable.

## Test plan
- Reset with `RESET_PC` = 32'h0000_0040, memory ready with 1-cycle response → first `req_addr` = 0x40, then 0x44, then 0x48. `instr_pc` follows, and `fetch_count` = 3 after three HOLD handshakes.
- `id_ready` held low for 5 cycles in HOLD → `instr`, `instr_pc` and `instr_valid` stay stable. No new `req_valid`. `fetch_count` increments once, on release.
- Redirect to 0x100 in WAIT before `resp_valid` → DROP. The next response is dropped, with no `instr_valid`. The next `req_addr` = 0x100.
- Redirect to 0x200 in the same cycle as `resp_valid` → the response is discarded, state goes to FETCH, and `req_addr` = 0x200.
- Redirect in HOLD while `id_ready` = 1 → the instruction is flushed and `fetch_count` is unchanged. The next `req_addr` = the target.
- `pc` = 0xFFFF_FFFC → `pc_plus4` = 0x0000_0000, and the fetch after it goes to address 0.
- `fetch_count` preloaded near 0xFFFF_FFFF via force → wraps to 0.
- `rst_n` asserted in WAIT → all outputs go to their reset values immediately. A late response after release is ignored.
